ps2_key_ctrl: RTL and testbench
===============================

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the clk100MHz cycles allowed between a prefix byte (E0/F0) and its follow-up byte (1 ms).
REQ-002 SHALL have port clk100MHz  input  1  system clock; the block has one clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx_byte  input  8  last scan-code byte from the PS/2 receiver.
REQ-005 SHALL have port rx_done  input  1  receiver byte-complete flag; asynchronous to clk100MHz; rx_byte is stable while it is high.
REQ-006 SHALL have port p1_dir  output  2  left-paddle command: 00 stop, 01 up, 10 down.
REQ-007 SHALL have port p2_dir  output  2  right-paddle command, same encoding.
REQ-008 SHALL have port keys_held  output  4  held-key levels: {Down, Up, S, W}.
REQ-009 SHALL have port timeout_err  output  1  one-cycle pulse when a prefix times out.
REQ-010 SHALL have port pause  output  1  pause toggle state.

Function
REQ-011 SHALL synchronise rx_done through two flops and detect its rising edge; rx_byte SHALL be captured on the edge-detect cycle.
REQ-012 SHALL update outputs on exactly the 4th clk100MHz rising edge after rx_done rises.
REQ-013 SHALL implement FSM states IDLE, EXT, BREAK and EXT_BREAK.
REQ-014 In any state, byte E0 SHALL move the FSM to EXT.
REQ-015 Byte F0 SHALL move IDLE->BREAK and EXT->EXT_BREAK; in BREAK or EXT_BREAK the state is unchanged.
REQ-016 Any other byte SHALL be decoded with make = (state is IDLE or EXT), ext = (state is EXT or EXT_BREAK); the FSM then returns to IDLE.
REQ-017 Key mapping: non-ext 1D -> W, non-ext 1B -> S, ext 75 -> Up, ext 72 -> Down.
REQ-018 A make SHALL set the key's held bit and a break SHALL clear it; repeated makes (typematic) leave it at 1.
REQ-019 Unmapped codes, AA and FA SHALL leave all held bits unchanged.
REQ-020 Bytes 00 and FF (overrun) SHALL clear all held bits and return the FSM to IDLE.
REQ-021 Direction decode: p1_dir = 01 if W only, 10 if S only, 00 if neither or both; p2_dir likewise from Up/Down.
REQ-022 Timeout counter: runs only while the FSM is not IDLE; clears on each captured byte.
REQ-023 On reaching TIMEOUT_CYCLES-1 the FSM SHALL go to IDLE, timeout_err SHALL pulse for 1 cycle, and held bits SHALL be unchanged.
REQ-024 If a byte edge and a timeout occur in the same cycle, the byte SHALL win and no timeout_err is issued.
REQ-025 Counter width SHALL be clog2(TIMEOUT_CYCLES) bits, saturating, with no wrap-around.

Reset
REQ-026 While rst_n=0: FSM=IDLE; synchronisers, counter and held bits=0; p1_dir=p2_dir=00; keys_held=0; timeout_err=0; pause=0.
REQ-027 Deassertion mid-frame SHALL resume in IDLE; an rx_done already high at release SHALL NOT produce an edge until it is seen low first.

Configuration
REQ-028 With macro PS2_PAUSE_KEY_EN defined, a non-ext make of 29 (Space) SHALL toggle pause only if Space was not already held; break 29 clears Space-held.
REQ-029 Without PS2_PAUSE_KEY_EN, pause SHALL be tied to 0 and code 29 SHALL be treated as unmapped.

Verification
REQ-030 Bytes 1D -> p1_dir=01 and keys_held=0001 exactly 4 cycles after the rx_done rise; then F0,1D -> p1_dir=00.
REQ-031 Bytes E0,75 then 1B -> p2_dir=01, p1_dir=10; E0,F0,75 -> p2_dir=00, keys_held=0010.
REQ-032 1D, 1B held -> p1_dir=00; then F0,1B -> p1_dir=01.
REQ-033 E0 then no byte for TIMEOUT_CYCLES (TIMEOUT_CYCLES=50 in bench) -> single timeout_err pulse, FSM IDLE; a following 72 decodes as non-ext and leaves keys_held unchanged.
REQ-034 Holding W, byte FF -> keys_held=0000; rst_n low mid-frame after E0 -> all outputs 0, and next byte 75 decodes as non-ext.
REQ-035 With PS2_PAUSE_KEY_EN: 29,29,29 -> pause=1; F0,29,29 -> pause=0. Without the macro: pause stays 0 throughout.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 scan-code decoder that turns W/S/Up/Down into two paddle direction commands.
// Ports:
//   clk100MHz   - system clock
//   rst_n       - asynchronous active-low reset
//   rx_byte     - last scan-code byte from the PS/2 receiver, stable while rx_done is high
//   rx_done     - byte-complete flag from the receiver, asynchronous to clk100MHz
//   p1_dir      - left paddle: 00 stop, 01 up, 10 down (W/S)
//   p2_dir      - right paddle, same encoding (Up/Down arrows)
//   keys_held   - held-key levels {Down, Up, S, W}
//   timeout_err - one-cycle pulse when a prefix byte is not followed in time
//   pause       - pause toggle state (Space); tied to 0 unless PS2_PAUSE_KEY_EN is defined
// Optional feature macro: PS2_PAUSE_KEY_EN
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk100MHz,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_done,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic [3:0] keys_held,
    output logic       timeout_err,
    output logic       pause
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    logic          r_s1, r_s2, r_s3;
    logic          r_v1, r_v2, r_arm;
    logic          r_vld;
    logic [7:0]    r_byte;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_held;
    logic          r_err;
    logic          w_edge, w_to, w_make, w_ext;
    logic [1:0]    w_state_nx;
    logic [3:0]    w_held_nx;

    // r_arm only sets once a genuine low sample of rx_done has passed the
    // synchroniser, so a flag already high at reset release is ignored.
    assign w_edge = r_arm & r_s2 & ~r_s3;
    assign w_make = ~r_state[1];
    assign w_ext  = r_state[0];
    // A byte in flight (edge seen or captured) always beats the timeout.
    assign w_to   = (r_state != S_IDLE) && (r_cnt == CMAX) && !w_edge && !r_vld;

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_arm  <= 1'b0;
            r_vld  <= 1'b0;
            r_byte <= 8'h00;
        end else begin
            r_s1   <= rx_done;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_v1   <= 1'b1;
            r_v2   <= r_v1;
            r_arm  <= r_arm | (r_v2 & ~r_s2);
            r_vld  <= w_edge;
            if (w_edge)
                r_byte <= rx_byte;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_held_nx  = r_held;
        if (r_vld) begin
            if (r_byte == 8'h00 || r_byte == 8'hFF) begin
                w_state_nx = S_IDLE;
                w_held_nx  = 4'b0000;
            end else if (r_byte == 8'hE0) begin
                w_state_nx = S_EXT;
            end else if (r_byte == 8'hF0) begin
                w_state_nx = (r_state == S_IDLE) ? S_BRK : (r_state == S_EXT) ? S_EXT_BRK : r_state;
            end else begin
                w_state_nx = S_IDLE;
                if (!w_ext && r_byte == 8'h1D) w_held_nx[0] = w_make;
                if (!w_ext && r_byte == 8'h1B) w_held_nx[1] = w_make;
                if ( w_ext && r_byte == 8'h75) w_held_nx[2] = w_make;
                if ( w_ext && r_byte == 8'h72) w_held_nx[3] = w_make;
            end
        end else if (w_to) begin
            w_state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_held  <= 4'b0000;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_held  <= w_held_nx;
            r_cnt   <= (r_vld || w_to || r_state == S_IDLE) ? '0 : (r_cnt == CMAX) ? r_cnt : r_cnt + 1'b1;
            r_err   <= w_to;
        end
    end

`ifdef PS2_PAUSE_KEY_EN
    logic r_space, r_pause;

    // Space toggles pause on its first make only; typematic repeats are ignored
    // until a break (or an overrun) clears the held flag.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_space <= 1'b0;
            r_pause <= 1'b0;
        end else if (r_vld && (r_byte == 8'h00 || r_byte == 8'hFF)) begin
            r_space <= 1'b0;
        end else if (r_vld && !w_ext && r_byte == 8'h29) begin
            r_space <= w_make;
            r_pause <= r_pause ^ (w_make & ~r_space);
        end
    end

    assign pause = r_pause;
`else
    assign pause = 1'b0;
`endif

    assign keys_held   = r_held;
    assign p1_dir      = {r_held[1] & ~r_held[0], r_held[0] & ~r_held[1]};
    assign p2_dir      = {r_held[3] & ~r_held[2], r_held[2] & ~r_held[3]};
    assign timeout_err = r_err;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: directed vector bench for ps2_key_ctrl with timeout, collision and reset sequences.
module tb_ps2_key_ctrl;
`ifdef PS2_PAUSE_KEY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk100MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_done = 1'b0;
    logic [1:0] p1_dir, p2_dir;
    logic [3:0] keys_held;
    logic       timeout_err, pause;

    int n_chk = 0;
    int n_fail = 0;
    logic [3:0] m_keys = 4'b0000;

    typedef struct {
        logic [7:0] b;
        logic [3:0] k;
        logic [1:0] d1;
        logic [1:0] d2;
        logic       p;
    } vec_t;
    vec_t tv[$];

    ps2_key_ctrl #(.TIMEOUT_CYCLES(50)) dut (
        .clk100MHz(clk100MHz), .rst_n(rst_n), .rx_byte(rx_byte), .rx_done(rx_done),
        .p1_dir(p1_dir), .p2_dir(p2_dir), .keys_held(keys_held),
        .timeout_err(timeout_err), .pause(pause)
    );

    always #5 clk100MHz = ~clk100MHz;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input logic [3:0] k, input logic [1:0] d1, input logic [1:0] d2, input logic p);
        tv.push_back('{b: b, k: k, d1: d1, d2: d2, p: p & PEN});
    endtask

    task automatic send(input string nm, input logic [7:0] b, input logic [3:0] k,
                        input logic [1:0] d1, input logic [1:0] d2, input logic p);
        @(negedge clk100MHz);
        rx_byte = b;
        rx_done = 1'b1;
        repeat (3) @(posedge clk100MHz);
        #1 chk({nm, " keys@3"}, {4'h0, keys_held}, {4'h0, m_keys});
        @(posedge clk100MHz);
        #1;
        chk({nm, " keys@4"}, {4'h0, keys_held}, {4'h0, k});
        chk({nm, " p1"}, {6'h0, p1_dir}, {6'h0, d1});
        chk({nm, " p2"}, {6'h0, p2_dir}, {6'h0, d2});
        chk({nm, " pause"}, {7'h0, pause}, {7'h0, p});
        chk({nm, " err"}, {7'h0, timeout_err}, 8'h00);
        m_keys = k;
        repeat (2) @(posedge clk100MHz);
        @(negedge clk100MHz) rx_done = 1'b0;
        repeat (4) @(posedge clk100MHz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_err, err_at;
        add(8'h1D, 4'b0001, 2'b01, 2'b00, 0);
        add(8'hF0, 4'b0001, 2'b01, 2'b00, 0);
        add(8'h1D, 4'b0000, 2'b00, 2'b00, 0);
        add(8'hE0, 4'b0000, 2'b00, 2'b00, 0);
        add(8'h75, 4'b0100, 2'b00, 2'b01, 0);
        add(8'h1B, 4'b0110, 2'b10, 2'b01, 0);
        add(8'hE0, 4'b0110, 2'b10, 2'b01, 0);
        add(8'hF0, 4'b0110, 2'b10, 2'b01, 0);
        add(8'h75, 4'b0010, 2'b10, 2'b00, 0);
        add(8'h1D, 4'b0011, 2'b00, 2'b00, 0);
        add(8'h1D, 4'b0011, 2'b00, 2'b00, 0);
        add(8'hF0, 4'b0011, 2'b00, 2'b00, 0);
        add(8'h1B, 4'b0001, 2'b01, 2'b00, 0);
        add(8'hAA, 4'b0001, 2'b01, 2'b00, 0);
        add(8'hFA, 4'b0001, 2'b01, 2'b00, 0);
        add(8'hE0, 4'b0001, 2'b01, 2'b00, 0);
        add(8'h72, 4'b1001, 2'b01, 2'b10, 0);
        add(8'h72, 4'b1001, 2'b01, 2'b10, 0);
        add(8'hE0, 4'b1001, 2'b01, 2'b10, 0);
        add(8'h1D, 4'b1001, 2'b01, 2'b10, 0);
        add(8'hF0, 4'b1001, 2'b01, 2'b10, 0);
        add(8'h75, 4'b1001, 2'b01, 2'b10, 0);
        add(8'hE0, 4'b1001, 2'b01, 2'b10, 0);
        add(8'hF0, 4'b1001, 2'b01, 2'b10, 0);
        add(8'h72, 4'b0001, 2'b01, 2'b00, 0);
        add(8'h29, 4'b0001, 2'b01, 2'b00, 1);
        add(8'h29, 4'b0001, 2'b01, 2'b00, 1);
        add(8'h29, 4'b0001, 2'b01, 2'b00, 1);
        add(8'hF0, 4'b0001, 2'b01, 2'b00, 1);
        add(8'h29, 4'b0001, 2'b01, 2'b00, 1);
        add(8'h29, 4'b0001, 2'b01, 2'b00, 0);
        add(8'hF0, 4'b0001, 2'b01, 2'b00, 0);
        add(8'hF0, 4'b0001, 2'b01, 2'b00, 0);
        add(8'h1D, 4'b0000, 2'b00, 2'b00, 0);
        add(8'h1D, 4'b0001, 2'b01, 2'b00, 0);
        add(8'hFF, 4'b0000, 2'b00, 2'b00, 0);
        add(8'h1B, 4'b0010, 2'b10, 2'b00, 0);
        add(8'h00, 4'b0000, 2'b00, 2'b00, 0);
        add(8'hE0, 4'b0000, 2'b00, 2'b00, 0);
        add(8'h00, 4'b0000, 2'b00, 2'b00, 0);
        add(8'h75, 4'b0000, 2'b00, 2'b00, 0);
        add(8'hF0, 4'b0000, 2'b00, 2'b00, 0);
        add(8'hE0, 4'b0000, 2'b00, 2'b00, 0);
        add(8'h75, 4'b0100, 2'b00, 2'b01, 0);
        add(8'hE0, 4'b0100, 2'b00, 2'b01, 0);
        add(8'hF0, 4'b0100, 2'b00, 2'b01, 0);
        add(8'h75, 4'b0000, 2'b00, 2'b00, 0);

        repeat (3) @(posedge clk100MHz);
        #1;
        chk("rst keys", {4'h0, keys_held}, 8'h00);
        chk("rst p1", {6'h0, p1_dir}, 8'h00);
        chk("rst p2", {6'h0, p2_dir}, 8'h00);
        chk("rst err", {7'h0, timeout_err}, 8'h00);
        chk("rst pause", {7'h0, pause}, 8'h00);
        @(negedge clk100MHz) rst_n = 1'b1;
        repeat (4) @(posedge clk100MHz);

        for (int i = 0; i < tv.size(); i++)
            send($sformatf("vec%0d", i), tv[i].b, tv[i].k, tv[i].d1, tv[i].d2, tv[i].p);

        // Prefix timeout: exactly one pulse, 50 cycles after E0 is decoded.
        send("to_w", 8'h1D, 4'b0001, 2'b01, 2'b00, 0);
        @(negedge clk100MHz);
        rx_byte = 8'hE0;
        rx_done = 1'b1;
        repeat (4) @(posedge clk100MHz);
        n_err = 0;
        err_at = 0;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk100MHz);
            #1;
            if (i == 2) rx_done = 1'b0;
            if (timeout_err) begin
                n_err++;
                err_at = i;
            end
        end
        chk("to pulses", 8'(n_err), 8'd1);
        chk("to cycle", 8'(err_at), 8'd50);
        chk("to keys", {4'h0, keys_held}, 8'h01);
        send("to_72", 8'h72, 4'b0001, 2'b01, 2'b00, 0);

        // Byte decode lands on the cycle the timeout would fire: byte wins.
        @(negedge clk100MHz);
        rx_byte = 8'hE0;
        rx_done = 1'b1;
        repeat (4) @(posedge clk100MHz);
        n_err = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk100MHz);
            #1;
            if (i == 2) rx_done = 1'b0;
            if (timeout_err) n_err++;
            if (i == 49) chk("col keys@49", {4'h0, keys_held}, 8'h01);
            if (i == 50) chk("col keys@50", {4'h0, keys_held}, 8'h05);
            if (i == 52) rx_done = 1'b0;
            if (i == 46) begin
                @(negedge clk100MHz);
                rx_byte = 8'h75;
                rx_done = 1'b1;
            end
        end
        chk("col pulses", 8'(n_err), 8'd0);
        chk("col p2", {6'h0, p2_dir}, 8'h01);
        m_keys = 4'b0101;

        // Reset in the middle of an extended sequence.
        send("mr_e0", 8'hE0, 4'b0101, 2'b01, 2'b01, 0);
        @(negedge clk100MHz) rst_n = 1'b0;
        #1;
        chk("mr keys", {4'h0, keys_held}, 8'h00);
        chk("mr p1", {6'h0, p1_dir}, 8'h00);
        chk("mr p2", {6'h0, p2_dir}, 8'h00);
        chk("mr err", {7'h0, timeout_err}, 8'h00);
        chk("mr pause", {7'h0, pause}, 8'h00);
        repeat (3) @(posedge clk100MHz);
        @(negedge clk100MHz) rst_n = 1'b1;
        m_keys = 4'b0000;
        repeat (3) @(posedge clk100MHz);
        send("mr_75", 8'h75, 4'b0000, 2'b00, 2'b00, 0);

        // rx_done already high at reset release must not register a byte.
        @(negedge clk100MHz);
        rx_byte = 8'h1D;
        rx_done = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk100MHz);
        @(negedge clk100MHz) rst_n = 1'b1;
        repeat (10) @(posedge clk100MHz);
        #1 chk("hr keys", {4'h0, keys_held}, 8'h00);
        @(negedge clk100MHz) rx_done = 1'b0;
        repeat (4) @(posedge clk100MHz);
        send("hr_1d", 8'h1D, 4'b0001, 2'b01, 2'b00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
